// File: rtl/branch_target_buffer_if.sv
// Lookup/update bus of the branch target buffer: F-stage lookup PC, M-stage
// resolution, and the registered D-stage prediction.
interface branch_target_buffer_if;
    logic        stallD;
    logic        flushD;
    logic [31:0] pcF;
    logic        branchM;
    logic        actual_takeM;
    logic [31:0] pcM;
    logic [31:0] targetM;
    logic        btb_hitD;
    logic [31:0] btb_targetD;

    modport master (
        output stallD, flushD, pcF, branchM, actual_takeM, pcM, targetM,
        input  btb_hitD, btb_targetD
    );

    modport slave (
        input  stallD, flushD, pcF, branchM, actual_takeM, pcM, targetM,
        output btb_hitD, btb_targetD
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational F-stage lookup with a
// write-first bypass from the M-stage update, registered into the D stage.
module branch_target_buffer #(
    parameter int unsigned ENTRIES    = 64,
    parameter int unsigned INDEX_BITS = 6
) (
    input logic                    clk,
    input logic                    rst,
    branch_target_buffer_if.slave  bus
);
    localparam int unsigned TagBits = 30 - INDEX_BITS;

    logic [ENTRIES-1:0] r_valid;
    logic [TagBits-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic               r_hit_d;
    logic [31:0]        r_target_d;

    logic [INDEX_BITS-1:0] w_idx_f;
    logic [INDEX_BITS-1:0] w_idx_m;
    logic [TagBits-1:0]    w_tag_f;
    logic [TagBits-1:0]    w_tag_m;
    logic                  w_m_match;
    logic                  w_install;
    logic                  w_inval;
    logic                  w_same_idx;
    logic                  w_ent_valid;
    logic [TagBits-1:0]    w_ent_tag;
    logic [31:0]           w_ent_target;
    logic                  w_hit_f;
    logic [31:0]           w_target_f;

    assign w_idx_f = bus.pcF[INDEX_BITS+1:2];
    assign w_tag_f = bus.pcF[31:INDEX_BITS+2];
    assign w_idx_m = bus.pcM[INDEX_BITS+1:2];
    assign w_tag_m = bus.pcM[31:INDEX_BITS+2];

    assign w_m_match  = r_valid[w_idx_m] && (r_tag[w_idx_m] == w_tag_m);
    assign w_install  = bus.branchM && bus.actual_takeM;
    assign w_inval    = bus.branchM && !bus.actual_takeM && w_m_match;
    assign w_same_idx = (w_idx_f == w_idx_m);

    // Write-first: a same-index update is forwarded into the lookup.
    always_comb begin
        w_ent_valid  = r_valid[w_idx_f];
        w_ent_tag    = r_tag[w_idx_f];
        w_ent_target = r_target[w_idx_f];
        if (w_same_idx && w_install) begin
            w_ent_valid  = 1'b1;
            w_ent_tag    = w_tag_m;
            w_ent_target = bus.targetM;
        end else if (w_same_idx && w_inval) begin
            w_ent_valid  = 1'b0;
        end
    end

    assign w_hit_f    = w_ent_valid && (w_ent_tag == w_tag_f);
    assign w_target_f = w_hit_f ? w_ent_target : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_install) begin
            r_valid[w_idx_m] <= 1'b1;
        end else if (w_inval) begin
            r_valid[w_idx_m] <= 1'b0;
        end
    end

    // Tag/target need no reset; they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tag[w_idx_m]    <= w_tag_m;
            r_target[w_idx_m] <= bus.targetM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flushD) begin
            r_hit_d    <= 1'b0;
            r_target_d <= 32'd0;
        end else if (!bus.stallD) begin
            r_hit_d    <= w_hit_f;
            r_target_d <= w_target_f;
        end
    end

    assign bus.btb_hitD    = r_hit_d;
    assign bus.btb_targetD = r_target_d;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench: directed vector table for the named corner cases, then
// randomized traffic against a behavioural table model.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_target_buffer_if bus ();

    branch_target_buffer #(
        .ENTRIES    (64),
        .INDEX_BITS (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] pcf;
        logic        br;
        logic        take;
        logic [31:0] pcm;
        logic [31:0] tgtm;
        logic        exp_hit;
        logic [31:0] exp_tgt;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: a 64-entry table keyed by word index, tag = pc / 256.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    logic        m_hit_d;
    logic [31:0] m_tgt_d;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % 64;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / 256;
    endfunction

    task automatic model_step(input logic r, input logic st, input logic fl,
                              input logic [31:0] pcf, input logic br, input logic tk,
                              input logic [31:0] pcm, input logic [31:0] tgt);
        logic        hit;
        logic [31:0] t;
        if (r) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_hit_d = 1'b0;
            m_tgt_d = 32'd0;
        end else begin
            // Apply the update first: the lookup observes the updated table.
            if (br && tk) begin
                m_valid[idx_of(pcm)] = 1'b1;
                m_tag[idx_of(pcm)]   = tag_of(pcm);
                m_tgt[idx_of(pcm)]   = tgt;
            end else if (br && m_valid[idx_of(pcm)] && m_tag[idx_of(pcm)] == tag_of(pcm)) begin
                m_valid[idx_of(pcm)] = 1'b0;
            end
            hit = m_valid[idx_of(pcf)] && (m_tag[idx_of(pcf)] == tag_of(pcf));
            t   = hit ? m_tgt[idx_of(pcf)] : 32'd0;
            if (fl) begin
                m_hit_d = 1'b0;
                m_tgt_d = 32'd0;
            end else if (!st) begin
                m_hit_d = hit;
                m_tgt_d = t;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic st, input logic fl, input logic [31:0] pcf,
                         input logic br, input logic tk, input logic [31:0] pcm,
                         input logic [31:0] tgt);
        rst              = r;
        bus.stallD       = st;
        bus.flushD       = fl;
        bus.pcF          = pcf;
        bus.branchM      = br;
        bus.actual_takeM = tk;
        bus.pcM          = pcm;
        bus.targetM      = tgt;
        model_step(r, st, fl, pcf, br, tk, pcm, tgt);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic st, input logic fl,
                                input logic [31:0] pcf, input logic br, input logic tk,
                                input logic [31:0] pcm, input logic [31:0] tgt,
                                input logic eh, input logic [31:0] et);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = fl; v.pcf = pcf; v.br = br; v.take = tk;
        v.pcm = pcm; v.tgtm = tgt; v.exp_hit = eh; v.exp_tgt = et;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        //                r  st fl pcF           br tk pcM           targetM       hit tgt
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400020, 0, 0, 32'h0,        32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h00400020, 32'h00400100, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400020, 0, 0, 32'h0,        32'h0,        1, 32'h00400100));
        vecs.push_back(mk(0, 0, 0, 32'h00400120, 0, 0, 32'h0,        32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400020, 1, 0, 32'h00400120, 32'h0,        1, 32'h00400100));
        vecs.push_back(mk(0, 0, 0, 32'h00400020, 0, 0, 32'h0,        32'h0,        1, 32'h00400100));
        vecs.push_back(mk(0, 1, 0, 32'h00400120, 0, 0, 32'h0,        32'h0,        1, 32'h00400100));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h00400100));
        vecs.push_back(mk(0, 1, 0, 32'h00400040, 0, 0, 32'h0,        32'h0,        1, 32'h00400100));
        vecs.push_back(mk(0, 1, 1, 32'h00400020, 0, 0, 32'h0,        32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400020, 1, 0, 32'h00400020, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400020, 0, 0, 32'h0,        32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400040, 1, 1, 32'h00400040, 32'h00400040, 1, 32'h00400040));
        vecs.push_back(mk(0, 0, 0, 32'h00400040, 1, 1, 32'h00400080, 32'h00001000, 1, 32'h00400040));
        vecs.push_back(mk(0, 1, 0, 32'h00400080, 1, 1, 32'h004000C0, 32'h00002000, 1, 32'h00400040));
        vecs.push_back(mk(1, 0, 0, 32'h00400080, 1, 1, 32'h00400100, 32'h00003000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400100, 1, 1, 32'h00400200, 32'h00006000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400200, 0, 0, 32'h0,        32'h0,        1, 32'h00006000));
        vecs.push_back(mk(0, 0, 0, 32'h00400080, 0, 0, 32'h0,        32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h004000C0, 0, 0, 32'h0,        32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400080, 0, 1, 32'h00400080, 32'h00005000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400080, 0, 0, 32'h0,        32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00400203, 0, 0, 32'h0,        32'h0,        1, 32'h00006000));

        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
        end
        m_hit_d = 1'b0;
        m_tgt_d = 32'd0;

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].pcf,
                  vecs[i].br, vecs[i].take, vecs[i].pcm, vecs[i].tgtm);
            check($sformatf("vec%0d hit", i), {31'd0, bus.btb_hitD}, {31'd0, vecs[i].exp_hit});
            check($sformatf("vec%0d target", i), bus.btb_targetD, vecs[i].exp_tgt);
        end

        // Random traffic; a small PC pool makes hits and index aliasing frequent.
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pf, pm;
            pf = 32'h00400000 | ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
            pm = ($urandom_range(0, 3) == 0) ? pf
               : (32'h00400000 | ($urandom_range(0, 255) << 2) | $urandom_range(0, 3));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, pf, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, pm, $urandom);
            check($sformatf("rand%0d hit", c), {31'd0, bus.btb_hitD}, {31'd0, m_hit_d});
            check($sformatf("rand%0d target", c), bus.btb_targetD, m_tgt_d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 64, meaning the number of direct-mapped table entries.
REQ-002 The block SHALL have parameter INDEX_BITS, default 6, equal to log2(ENTRIES).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port stallD, input, 1 bit: hold the D-stage outputs.
REQ-006 The block SHALL have port flushD, input, 1 bit: clear the D-stage outputs.
REQ-007 The block SHALL have port pcF, input, 32 bits: fetch-stage PC used for lookup.
REQ-008 The block SHALL have port branchM, input, 1 bit: the M-stage instruction is a conditional branch.
REQ-009 The block SHALL have port actual_takeM, input, 1 bit: the resolved outcome of the M-stage branch.
REQ-010 The block SHALL have port pcM, input, 32 bits: PC of the M-stage branch.
REQ-011 The block SHALL have port targetM, input, 32 bits: resolved target of the M-stage branch.
REQ-012 The block SHALL have port btb_hitD, output, 1 bit: D-stage instruction hit a valid BTB entry.
REQ-013 The block SHALL have port btb_targetD, output, 32 bits: predicted target for the D-stage instruction.

Function
REQ-014 Index SHALL be pc[INDEX_BITS+1:2]; tag SHALL be pc[31:INDEX_BITS+2]; pc[1:0] SHALL be ignored.
REQ-015 Each entry SHALL hold a valid bit, a tag, and a 32-bit target.
REQ-016 F-stage lookup SHALL be combinational: hitF = valid[idx(pcF)] AND tag[idx(pcF)] == tag(pcF); targetF = target[idx(pcF)].
REQ-017 hitF and targetF SHALL be registered into btb_hitD/btb_targetD, one cycle of latency, lining up with pcD and pred_takeD of the direction predictor.
REQ-018 D-register priority SHALL be rst, then flushD (load 0/0), then stallD (hold), else load hitF/targetF.
REQ-019 When targetF is not a hit, btb_targetD SHALL be 0 (hit=0 implies target=0).
REQ-020 Update on branchM=1, actual_takeM=1: entry idx(pcM) SHALL be written valid=1, tag(pcM), targetM, replacing any prior occupant.
REQ-021 Update on branchM=1, actual_takeM=0: if entry idx(pcM) is valid with tag(pcM), it SHALL be invalidated; otherwise no change.
REQ-022 branchM=0 SHALL leave the table unchanged regardless of actual_takeM.
REQ-023 Same-cycle update and lookup to the same index SHALL be write-first: the lookup sees the post-update entry.
REQ-024 Table updates SHALL proceed during stallD and flushD; only the D register is affected by these signals.
REQ-025 An update with pcM equal to targetM SHALL be stored normally; no special-casing.

Reset
REQ-026 With rst=1 at a clock edge, all valid bits SHALL clear and btb_hitD=0, btb_targetD=0 after that edge.
REQ-027 Tag/target arrays SHALL NOT require reset; their contents are unobservable while valid=0.
REQ-028 rst asserted mid-operation SHALL override any same-cycle update; the table is empty after the edge.
REQ-029 In the first cycle after rst deasserts, lookups SHALL miss and updates SHALL take effect normally.

Verification
REQ-030 Cold miss: after reset, pcF=0x00400020 -> next cycle btb_hitD=0, btb_targetD=0.
REQ-031 Install/hit: branchM=1, actual_takeM=1, pcM=0x00400020, targetM=0x00400100; later pcF=0x00400020 -> btb_hitD=1, btb_targetD=0x00400100.
REQ-032 Alias/tag mismatch: after REQ-031, pcF=0x00400120 (same index 8, different tag) -> btb_hitD=0; not-taken at pcM=0x00400120 leaves the 0x00400020 entry valid.
REQ-033 Invalidate + bypass: same cycle branchM=1, actual_takeM=0, pcM=0x00400020, pcF=0x00400020 -> next cycle btb_hitD=0.
REQ-034 Stall/flush: hit captured, stallD=1 for 3 cycles while pcF changes -> outputs held; flushD=1 with stallD=1 -> outputs 0 next cycle.
REQ-035 Reset mid-run: several entries installed, rst=1 coincident with a taken update -> all subsequent lookups miss until reinstalled.
